rv_issue_ctrl: RTL

In-order issue controller between the fetch/decode unit and the ALU. It holds a 32-entry register scoreboard and gates each decoded instruction until its source and destination registers are free, the ALU is ready and the in-flight limit allows. It presents one registered ALU op per accepted instruction and clears scoreboard bits on register-file writeback. It also exposes stall state and a stall-cycle counter for performance debug.

---
 rtl/rv_pkg.sv | 30 +++
 rtl/rv_scoreboard.sv | 55 +++++
 rtl/rv_issue_ctrl.sv | 83 ++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared types and constants for the rv issue path: stall-state encoding,
// ALU op codes, register-index width and the scoreboard lookup request.
package rv_pkg;
   localparam int REG_W    = 5;
   localparam int NUM_REGS = 1 << REG_W;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      STALL_RAW = 2'd2,
      STALL_RES = 2'd3
   } stall_state_t;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_OR  = 4'b0010;
   localparam logic [3:0] ALU_AND = 4'b0011;

   typedef struct packed {
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic             uses_rs2;
      logic [REG_W-1:0] rd;
      logic             wr_en;
   } sb_req_t;

   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_W-1:0] idx);
      return NUM_REGS'(1) << idx;
   endfunction
endpackage

// File: rtl/rv_scoreboard.sv
// Register busy vector, hazard lookup and in-flight count.
// RV_ISSUE_BYPASS_EN lets a same-cycle writeback clear hide the hazard.
module rv_scoreboard
   import rv_pkg::*;
#(
   parameter int MAX_INFLIGHT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  sb_req_t          req,
   input  logic             set_en,
   input  logic             wb_valid,
   input  logic [REG_W-1:0] wb_addr,
   output logic             hazard,
   output logic             limit_hit,
   output logic             wb_spurious
);
   logic [NUM_REGS-1:0] busy, clr_mask, set_mask, chk_busy;
   logic [3:0]          inflight;
   logic                clr_en, set_cnt, wb_nz;

   assign wb_nz       = wb_valid && (wb_addr != '0);
   assign clr_en      = wb_nz && busy[wb_addr];
   assign wb_spurious = wb_nz && !busy[wb_addr];
   assign clr_mask    = clr_en ? reg_onehot(wb_addr) : '0;
   // x0 is never marked busy, so it can never cause a hazard
   assign set_cnt     = set_en && req.wr_en && (req.rd != '0);
   assign set_mask    = set_cnt ? reg_onehot(req.rd) : '0;

`ifdef RV_ISSUE_BYPASS_EN
   assign chk_busy = busy & ~clr_mask;
`else
   assign chk_busy = busy;
`endif

   assign hazard = chk_busy[req.rs1]
                || (req.uses_rs2 && chk_busy[req.rs2])
                || (req.wr_en && chk_busy[req.rd]);
   assign limit_hit = (inflight >= 4'(MAX_INFLIGHT));

   // set is applied after clear so a same-register collision leaves the bit busy
   always_ff @(posedge clk) begin
      if (reset) begin
         busy     <= '0;
         inflight <= '0;
      end else begin
         busy <= (busy & ~clr_mask) | set_mask;
         case ({set_cnt, clr_en})
            2'b10:   inflight <= inflight + 4'd1;
            2'b01:   inflight <= inflight - 4'd1;
            default: inflight <= inflight;
         endcase
      end
   end
endmodule

// File: rtl/rv_issue_ctrl.sv
// In-order issue controller: gates decoded ops on scoreboard hazards, ALU
// readiness and in-flight limit. Optional RV_ISSUE_BYPASS_EN (see rv_scoreboard).
module rv_issue_ctrl
   import rv_pkg::*;
#(
   parameter int MAX_INFLIGHT = 4,
   parameter int STALL_CNT_W  = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   dec_valid,
   output logic                   dec_rdy,
   input  logic [REG_W-1:0]       dec_rs1,
   input  logic [REG_W-1:0]       dec_rs2,
   input  logic                   dec_uses_rs2,
   input  logic [REG_W-1:0]       dec_rd,
   input  logic                   dec_wr_en,
   input  logic [3:0]             dec_op,
   input  logic                   alu_rdy,
   output logic                   alu_op_valid,
   output logic [3:0]             alu_op,
   output logic [REG_W-1:0]       alu_addr,
   input  logic                   wb_valid,
   input  logic [REG_W-1:0]       wb_addr,
   output logic [1:0]             stall_state,
   output logic [STALL_CNT_W-1:0] stall_cnt,
   output logic                   sb_err
);
   sb_req_t      req;
   stall_state_t state_q, state_d;
   logic         hazard, limit_hit, wb_spurious, accept, vld_q;

   assign req = '{rs1: dec_rs1, rs2: dec_rs2, uses_rs2: dec_uses_rs2,
                  rd: dec_rd, wr_en: dec_wr_en};

   rv_scoreboard #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_sb (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .set_en      (accept),
      .wb_valid    (wb_valid),
      .wb_addr     (wb_addr),
      .hazard      (hazard),
      .limit_hit   (limit_hit),
      .wb_spurious (wb_spurious)
   );

   assign dec_rdy = alu_rdy && !hazard && !limit_hit;
   assign accept  = dec_valid && dec_rdy;

   always_comb begin
      state_d = IDLE;
      if (!dec_valid)  state_d = IDLE;
      else if (dec_rdy) state_d = ISSUE;
      else if (hazard)  state_d = STALL_RAW;
      else              state_d = STALL_RES;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         vld_q     <= 1'b0;
         alu_op    <= '0;
         alu_addr  <= '0;
         stall_cnt <= '0;
         sb_err    <= 1'b0;
      end else begin
         state_q <= state_d;
         vld_q   <= accept;
         if (accept) begin
            alu_op   <= dec_op;
            alu_addr <= dec_rd;
         end
         if ((state_d == STALL_RAW || state_d == STALL_RES) && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
         if (wb_spurious)
            sb_err <= 1'b1;
      end
   end

   assign alu_op_valid = vld_q;
   assign stall_state  = state_q;
endmodule
